// File: rtl/noc_local_ni.sv
// Network interface between a processing element and a router Local port: TX flit packing with
// credit-based injection, RX buffering with per-flit credit return. Optional stats: NOC_NI_STATS_EN.
module noc_local_ni #(
  parameter logic [3:0] XCOORD   = 4'hF,
  parameter logic [3:0] YCOORD   = 4'hF,
  parameter int         CREDITS  = 4,
  parameter int         TX_DEPTH = 4,
  parameter int         RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_dest,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  input  logic        rx_ready,
  output logic [15:0] net_data_o,
  output logic        net_enable_o,
  input  logic        net_credit_i,
  input  logic [15:0] net_data_i,
  input  logic        net_enable_i,
  output logic        net_credit_o,
  output logic        err_o
`ifdef NOC_NI_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
`endif
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int CW    = $clog2(CREDITS + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [15:0]        tx_mem_q [TX_DEPTH];
  logic [15:0]        tx_mem_d [TX_DEPTH];
  logic [15:0]        rx_mem_q [RX_DEPTH];
  logic [15:0]        rx_mem_d [RX_DEPTH];
  logic [TX_AW:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_AW:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [15:0]        net_data_q, net_data_d;
  logic               net_credit_q, net_credit_d;
  logic               err_q, err_d;
  logic [15:0]        tx_count_q, tx_count_d;
  logic [15:0]        rx_count_q, rx_count_d;

  logic tx_empty, tx_full, tx_push, tx_send;
  logic rx_empty, rx_full, rx_push, rx_pop, rx_drop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

  assign tx_ready = rst & ~tx_full;
  assign tx_push  = tx_valid & tx_ready;
  assign tx_send  = ~tx_empty & (credit_q != '0);

  // A full RX FIFO still takes a write when the head leaves in the same cycle.
  assign rx_pop   = ~rx_empty & rx_ready;
  assign rx_push  = net_enable_i & (~rx_full | rx_pop);
  assign rx_drop  = net_enable_i & rx_full & ~rx_pop;

  assign rx_valid     = ~rx_empty;
  assign rx_data      = rx_mem_q[rx_rd_q[RX_AW-1:0]];
  assign net_data_o   = net_data_q;
  assign net_enable_o = (state_q == SEND);
  assign net_credit_o = net_credit_q;
  assign err_o        = err_q;

`ifdef NOC_NI_STATS_EN
  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`endif

  always_comb begin
    state_d      = IDLE;
    tx_mem_d     = tx_mem_q;
    rx_mem_d     = rx_mem_q;
    tx_wr_d      = tx_wr_q;
    tx_rd_d      = tx_rd_q;
    rx_wr_d      = rx_wr_q;
    rx_rd_d      = rx_rd_q;
    credit_d     = credit_q;
    net_data_d   = net_data_q;
    net_credit_d = rx_pop;
    err_d        = err_q | rx_drop;
    tx_count_d   = tx_count_q;
    rx_count_d   = rx_count_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_q[TX_AW-1:0]] = {XCOORD, YCOORD, tx_dest};
      tx_wr_d = tx_wr_q + 1'b1;
    end

    if (tx_send) begin
      state_d    = SEND;
      net_data_d = tx_mem_q[tx_rd_q[TX_AW-1:0]];
      tx_rd_d    = tx_rd_q + 1'b1;
      tx_count_d = tx_count_q + 1'b1;
    end

    // A returned credit in the same cycle as a send cancels the decrement.
    if (tx_send && !net_credit_i) begin
      credit_d = credit_q - 1'b1;
    end else if (!tx_send && net_credit_i) begin
      if (credit_q == CW'(CREDITS)) err_d = 1'b1;
      else                          credit_d = credit_q + 1'b1;
    end

    if (rx_pop) begin
      rx_rd_d    = rx_rd_q + 1'b1;
      rx_count_d = rx_count_q + 1'b1;
    end

    if (rx_push) begin
      rx_mem_d[rx_wr_q[RX_AW-1:0]] = net_data_i;
      rx_wr_d = rx_wr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      credit_q     <= CW'(CREDITS);
      net_data_q   <= '0;
      net_credit_q <= 1'b0;
      err_q        <= 1'b0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      credit_q     <= credit_d;
      net_data_q   <= net_data_d;
      net_credit_q <= net_credit_d;
      err_q        <= err_d;
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
    end
  end

  // FIFO storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: tb/tb_noc_local_ni.sv
// Self-checking bench for noc_local_ni: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_noc_local_ni;

  localparam int CREDITS  = 4;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic [7:0]  tx_dest;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic [15:0] net_data_o;
  logic        net_enable_o;
  logic        net_credit_i;
  logic [15:0] net_data_i;
  logic        net_enable_i;
  logic        net_credit_o;
  logic        err_o;
`ifdef NOC_NI_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] rx_count;
`endif

  always #5 clk = ~clk;

  noc_local_ni #(
    .XCOORD(4'h1), .YCOORD(4'h0), .CREDITS(CREDITS), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_dest(tx_dest), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .net_data_o(net_data_o), .net_enable_o(net_enable_o), .net_credit_i(net_credit_i),
    .net_data_i(net_data_i), .net_enable_i(net_enable_i), .net_credit_o(net_credit_o),
    .err_o(err_o)
`ifdef NOC_NI_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: flit queues, credit count, registered outputs.
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  int          m_credit;
  bit          m_en, m_co, m_err;
  logic [15:0] m_data;
  int          m_txc, m_rxc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit send, pop, accept;
    if (!rst) begin
      m_tx.delete(); m_rx.delete();
      m_credit = CREDITS; m_en = 0; m_co = 0; m_err = 0; m_data = '0;
      m_txc = 0; m_rxc = 0;
      return;
    end
    send   = (m_tx.size() > 0) && (m_credit > 0);
    accept = tx_valid && (m_tx.size() < TX_DEPTH);
    pop    = (m_rx.size() > 0) && rx_ready;
    m_en = send;
    if (send) begin
      m_data = m_tx.pop_front();
      m_txc  = (m_txc + 1) & 16'hFFFF;
    end
    if (accept) m_tx.push_back({4'h1, 4'h0, tx_dest});
    if (net_credit_i && !send) begin
      if (m_credit == CREDITS) m_err = 1;
      else                     m_credit++;
    end else if (send && !net_credit_i) begin
      m_credit--;
    end
    m_co = pop;
    if (pop) begin
      void'(m_rx.pop_front());
      m_rxc = (m_rxc + 1) & 16'hFFFF;
    end
    if (net_enable_i) begin
      if (m_rx.size() < RX_DEPTH) m_rx.push_back(net_data_i);
      else                        m_err = 1;
    end
  endtask

  task automatic check_model();
    check("m_tx_ready", tx_ready, (rst && m_tx.size() < TX_DEPTH));
    check("m_net_enable", net_enable_o, m_en);
    if (m_en) check("m_net_data", net_data_o, m_data);
    check("m_rx_valid", rx_valid, m_rx.size() > 0);
    if (m_rx.size() > 0) check("m_rx_data", rx_data, m_rx[0]);
    check("m_net_credit_o", net_credit_o, m_co);
    check("m_err", err_o, m_err);
`ifdef NOC_NI_STATS_EN
    check("m_tx_count", tx_count, m_txc);
    check("m_rx_count", rx_count, m_rxc);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    tx_valid = 0; tx_dest = '0; rx_ready = 0; net_credit_i = 0;
    net_data_i = '0; net_enable_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    #1;
    check("rst_tx_ready", tx_ready, 0);
    cyc();
    cyc();
    check("rst_net_data", net_data_o, 0);
    check("rst_net_enable", net_enable_o, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err_o, 0);
    rst = 1;
    #1;
    check("rst_release_tx_ready", tx_ready, 1);
  endtask

  typedef struct {
    bit tv; logic [7:0] td; bit ci; bit ei; logic [15:0] di; bit rr;
    bit x_en; logic [15:0] x_data; bit x_trdy; bit x_rv; logic [15:0] x_rd; bit x_co; bit x_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, acc, co_cnt, r_owed, r_rx;
    logic [15:0] got[$];

    // Send 8'h21 from (1,0), receive 16'hABCD, then overflow the credit counter.
    tbl[0] = '{1'b1, 8'h21, 1'b0, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h1021, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hABCD, 1'b1,  1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1,  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      tx_valid = tbl[i].tv; tx_dest = tbl[i].td; net_credit_i = tbl[i].ci;
      net_enable_i = tbl[i].ei; net_data_i = tbl[i].di; rx_ready = tbl[i].rr;
      cyc();
      check($sformatf("tbl%0d_en", i), net_enable_o, tbl[i].x_en);
      if (tbl[i].x_en) check($sformatf("tbl%0d_data", i), net_data_o, tbl[i].x_data);
      check($sformatf("tbl%0d_tx_ready", i), tx_ready, tbl[i].x_trdy);
      check($sformatf("tbl%0d_rx_valid", i), rx_valid, tbl[i].x_rv);
      if (tbl[i].x_rv) check($sformatf("tbl%0d_rx_data", i), rx_data, tbl[i].x_rd);
      check($sformatf("tbl%0d_credit_o", i), net_credit_o, tbl[i].x_co);
      check($sformatf("tbl%0d_err", i), err_o, tbl[i].x_err);
    end

    // Credit exhaustion: only CREDITS sends, then the TX FIFO fills.
    do_reset();
    pulses = 0; acc = 0;
    for (int i = 0; i < 12; i++) begin
      tx_valid = 1; tx_dest = 8'h30 + 8'(i);
      if (tx_ready) acc++;
      cyc();
      if (net_enable_o) pulses++;
    end
    tx_valid = 0;
    check("stall_sends", pulses, 4);
    check("stall_accepted", acc, 8);
    check("stall_tx_ready", tx_ready, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      net_credit_i = (i < 2);
      cyc();
      if (net_enable_o) pulses++;
    end
    net_credit_i = 0;
    check("stall_resume_sends", pulses, 2);

    // Credit arriving in the same cycle as a send at credit=2, then overflow at CREDITS.
    do_reset();
    tx_valid = 1; tx_dest = 8'h41; cyc();
    tx_dest = 8'h42; cyc();
    tx_dest = 8'h43; cyc();
    tx_valid = 0; net_credit_i = 1; cyc();
    check("same_cycle_en", net_enable_o, 1);
    check("same_cycle_data", net_data_o, 16'h1043);
    cyc(); cyc();
    check("credit_at_max_err", err_o, 0);
    cyc();
    net_credit_i = 0;
    check("credit_overflow_err", err_o, 1);
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      tx_valid = (i < 5); tx_dest = 8'h50 + 8'(i);
      cyc();
      if (net_enable_o) pulses++;
    end
    check("credit_stays_max", pulses, 4);

    // RX overflow: fifth write dropped, drain shows first four in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      net_enable_i = 1; net_data_i = 16'hC000 + 16'(i);
      cyc();
    end
    net_enable_i = 0;
    check("rx_ovf_err", err_o, 1);
    check("rx_ovf_valid", rx_valid, 1);
    rx_ready = 1; co_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rx_valid) got.push_back(rx_data);
      cyc();
      if (net_credit_o) co_cnt++;
    end
    rx_ready = 0;
    check("rx_drain_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("rx_drain%0d", i), got[i], 16'hC000 + 16'(i));
    check("rx_credit_pulses", co_cnt, 4);

    // Reset during a TX stall with three flits queued.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tx_valid = 1; tx_dest = 8'h60 + 8'(i);
      cyc();
    end
    rst = 0;
    #1;
    check("midrst_tx_ready", tx_ready, 0);
    cyc();
    check("midrst_en", net_enable_o, 0);
    check("midrst_rx_valid", rx_valid, 0);
    rst = 1; tx_valid = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (net_enable_o) pulses++;
    end
    check("midrst_no_send", pulses, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tx_valid = (i < 4); tx_dest = 8'h70 + 8'(i);
      cyc();
      if (net_enable_o) pulses++;
    end
    tx_valid = 0;
    check("midrst_credit_restored", pulses, 4);

    // Randomized traffic against a router that honours credits (with rare violations).
    do_reset();
    r_owed = 0; r_rx = RX_DEPTH;
    for (int i = 0; i < 3000; i++) begin
      tx_valid = $urandom_range(0, 1) == 1;
      tx_dest  = 8'($urandom);
      rx_ready = $urandom_range(0, 3) != 0;
      net_credit_i = (r_owed > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 999) == 0);
      if (net_credit_i && r_owed > 0) r_owed--;
      net_enable_i = (r_rx > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 999) == 0);
      net_data_i   = 16'($urandom);
      if (net_enable_i && r_rx > 0) r_rx--;
      cyc();
      if (net_enable_o) r_owed++;
      if (net_credit_o && r_rx < RX_DEPTH) r_rx++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
